// File: rtl/inst_fetch_port.sv
// inst_fetch_port
// ---------------
// Memory-side responder for the PC stage's instruction fetch. The fetch
// virtual address is translated (kseg0/kseg1 by masking, everything else via
// an external combinational TLB). A single-word bus read is then issued, and
// the returned word is held in a tagged result register until the PC stage
// moves on. A fetch that faults in translation, or is misaligned, never
// reaches the bus: its result is written directly with data 0.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   pc_i, ce_i            fetch virtual address and fetch enable
//   pc_data_o             instruction word (meaningful when ready for pc_i)
//   pc_ready_o            result valid for the current pc_i, or PC stage idle
//   pc_tlbl_o             TLB refill/invalid on this fetch
//   pc_tlbs_o             store TLB fault, always 0 for fetches
//   pc_mcheck_o           machine check, multiple TLB entries matched
//   tlb_vaddr_o           address presented to the TLB (equals pc_i)
//   tlb_hit_i/valid_i/multi_i/paddr_i   TLB lookup result
//   bus_req_o, bus_addr_o read request and physical word address
//   bus_ack_i, bus_data_i read data strobe and data

module inst_fetch_port #(
    parameter logic [31:0] UNMAPPED_MASK = 32'h1FFFFFFF,
    parameter bit          USE_TLB       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    output logic [31:0] pc_data_o,
    output logic        pc_ready_o,
    output logic        pc_tlbl_o,
    output logic        pc_tlbs_o,
    output logic        pc_mcheck_o,
    output logic [31:0] tlb_vaddr_o,
    input  logic        tlb_hit_i,
    input  logic        tlb_valid_i,
    input  logic        tlb_multi_i,
    input  logic [31:0] tlb_paddr_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i
);

    typedef enum logic {
        IDLE,
        BUS
    } state_t;

    state_t      state, state_next;

    logic        res_valid, res_valid_next;
    logic [31:0] res_addr, res_addr_next;
    logic [31:0] res_data, res_data_next;
    logic        res_tlbl, res_tlbl_next;
    logic        res_mcheck, res_mcheck_next;
    logic [31:0] req_addr, req_addr_next;
    logic        bus_req_next;
    logic [31:0] bus_addr_next;

    logic        hit;
    logic        unmapped;
    logic [31:0] paddr;
    logic        xl_tlbl;
    logic        xl_mcheck;

    // The result register answers the PC stage only for the exact address it
    // was fetched for; a redirected pc_i simply misses and triggers a refetch.
    assign hit         = res_valid && (res_addr == pc_i);
    assign pc_ready_o  = ~ce_i | hit;
    assign pc_data_o   = res_data;
    assign pc_tlbl_o   = res_tlbl;
    assign pc_mcheck_o = res_mcheck;
    assign pc_tlbs_o   = 1'b0;
    assign tlb_vaddr_o = pc_i;

    // Address translation. kseg0 and kseg1 share the top two bits 2'b10.
    // A multiple match outranks a miss so the machine check is never hidden.
    always_comb begin
        unmapped  = (pc_i[31:30] == 2'b10);
        paddr     = pc_i & UNMAPPED_MASK;
        xl_tlbl   = 1'b0;
        xl_mcheck = 1'b0;
        if (USE_TLB && !unmapped) begin
            if (tlb_multi_i) begin
                xl_mcheck = 1'b1;
            end else if (!tlb_hit_i || !tlb_valid_i) begin
                xl_tlbl = 1'b1;
            end else begin
                paddr = tlb_paddr_i;
            end
        end
    end

    // Next-state logic. A BUS transaction is never aborted; its result is
    // tagged with the address it was started for, so a pc_i change mid-flight
    // just shows up as a miss once we are back in IDLE.
    always_comb begin
        state_next      = state;
        res_valid_next  = res_valid;
        res_addr_next   = res_addr;
        res_data_next   = res_data;
        res_tlbl_next   = res_tlbl;
        res_mcheck_next = res_mcheck;
        req_addr_next   = req_addr;
        bus_req_next    = bus_req_o;
        bus_addr_next   = bus_addr_o;

        case (state)
            IDLE: begin
                if (ce_i && !hit) begin
                    if (pc_i[1:0] != 2'b00) begin
                        // Misaligned: the PC stage raises AdEL on its own.
                        res_valid_next  = 1'b1;
                        res_addr_next   = pc_i;
                        res_data_next   = 32'h0;
                        res_tlbl_next   = 1'b0;
                        res_mcheck_next = 1'b0;
                    end else if (xl_tlbl || xl_mcheck) begin
                        res_valid_next  = 1'b1;
                        res_addr_next   = pc_i;
                        res_data_next   = 32'h0;
                        res_tlbl_next   = xl_tlbl;
                        res_mcheck_next = xl_mcheck;
                    end else begin
                        req_addr_next = pc_i;
                        bus_addr_next = paddr;
                        bus_req_next  = 1'b1;
                        state_next    = BUS;
                    end
                end
            end
            BUS: begin
                if (bus_ack_i) begin
                    bus_req_next    = 1'b0;
                    res_valid_next  = 1'b1;
                    res_addr_next   = req_addr;
                    res_data_next   = bus_data_i;
                    res_tlbl_next   = 1'b0;
                    res_mcheck_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                bus_req_next = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            res_valid  <= 1'b0;
            res_addr   <= 32'h0;
            res_data   <= 32'h0;
            res_tlbl   <= 1'b0;
            res_mcheck <= 1'b0;
            req_addr   <= 32'h0;
            bus_req_o  <= 1'b0;
            bus_addr_o <= 32'h0;
        end else begin
            state      <= state_next;
            res_valid  <= res_valid_next;
            res_addr   <= res_addr_next;
            res_data   <= res_data_next;
            res_tlbl   <= res_tlbl_next;
            res_mcheck <= res_mcheck_next;
            req_addr   <= req_addr_next;
            bus_req_o  <= bus_req_next;
            bus_addr_o <= bus_addr_next;
        end
    end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Directed testbench for inst_fetch_port. Inputs are driven 1 time unit after
// the rising edge and outputs are checked on the falling edge of the same
// cycle, so "cycle N" below means the Nth rising edge after a new pc_i.

module tb_inst_fetch_port;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [31:0] pc_data_o;
    logic        pc_ready_o;
    logic        pc_tlbl_o;
    logic        pc_tlbs_o;
    logic        pc_mcheck_o;
    logic [31:0] tlb_vaddr_o;
    logic        tlb_hit_i;
    logic        tlb_valid_i;
    logic        tlb_multi_i;
    logic [31:0] tlb_paddr_i;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_data_i;

    int check_count = 0;
    int pass_count  = 0;

    inst_fetch_port dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .pc_data_o   (pc_data_o),
        .pc_ready_o  (pc_ready_o),
        .pc_tlbl_o   (pc_tlbl_o),
        .pc_tlbs_o   (pc_tlbs_o),
        .pc_mcheck_o (pc_mcheck_o),
        .tlb_vaddr_o (tlb_vaddr_o),
        .tlb_hit_i   (tlb_hit_i),
        .tlb_valid_i (tlb_valid_i),
        .tlb_multi_i (tlb_multi_i),
        .tlb_paddr_i (tlb_paddr_i),
        .bus_req_o   (bus_req_o),
        .bus_addr_o  (bus_addr_o),
        .bus_ack_i   (bus_ack_i),
        .bus_data_i  (bus_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0;
        tlb_hit_i = 1'b0; tlb_valid_i = 1'b0; tlb_multi_i = 1'b0; tlb_paddr_i = 32'h0;
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_count++;
        if (bus_req_o !== 1'b0) $display("[TB] FAIL reset_bus_req: got %0b expected 0", bus_req_o);
        else pass_count++;
        check_count++;
        if (bus_addr_o !== 32'h0) $display("[TB] FAIL reset_bus_addr: got %h expected 00000000", bus_addr_o);
        else pass_count++;
        check_count++;
        if (pc_ready_o !== 1'b1) $display("[TB] FAIL reset_ready_ce0: got %0b expected 1", pc_ready_o);
        else pass_count++;
        ce_i = 1'b1;
        #1;
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL reset_ready_ce1: got %0b expected 0", pc_ready_o);
        else pass_count++;
        check_count++;
        if (pc_tlbs_o !== 1'b0) $display("[TB] FAIL reset_tlbs: got %0b expected 0", pc_tlbs_o);
        else pass_count++;
        next_cycle();
        rst = 1'b0;
        ce_i = 1'b0;
    endtask

    // kseg0 fetch with ack three cycles after the request.
    task automatic test_kseg0_fetch();
        next_cycle();
        pc_i = 32'h80000000; ce_i = 1'b1;
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL k0_c0_ready: got %0b expected 0", pc_ready_o);
        else pass_count++;
        next_cycle();
        @(negedge clk);
        check_count++;
        if (bus_req_o !== 1'b1) $display("[TB] FAIL k0_c1_req: got %0b expected 1", bus_req_o);
        else pass_count++;
        check_count++;
        if (bus_addr_o !== 32'h00000000) $display("[TB] FAIL k0_c1_addr: got %h expected 00000000", bus_addr_o);
        else pass_count++;
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL k0_c1_ready: got %0b expected 0", pc_ready_o);
        else pass_count++;
        next_cycle();
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL k0_c2_ready: got %0b expected 0", pc_ready_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b1; bus_data_i = 32'h3C1DBEEF;
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL k0_c3_ready: got %0b expected 0", pc_ready_o);
        else pass_count++;
        check_count++;
        if (bus_req_o !== 1'b1) $display("[TB] FAIL k0_c3_req: got %0b expected 1", bus_req_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b1) $display("[TB] FAIL k0_c4_ready: got %0b expected 1", pc_ready_o);
        else pass_count++;
        check_count++;
        if (pc_data_o !== 32'h3C1DBEEF) $display("[TB] FAIL k0_c4_data: got %h expected 3c1dbeef", pc_data_o);
        else pass_count++;
        check_count++;
        if (bus_req_o !== 1'b0) $display("[TB] FAIL k0_c4_req: got %0b expected 0", bus_req_o);
        else pass_count++;
    endtask

    // Sequential kseg1 fetches with zero-wait acks.
    task automatic test_back_to_back();
        logic [31:0] addrs [2];
        logic [31:0] paddrs [2];
        logic [31:0] words [2];
        addrs[0] = 32'hBFC00010; paddrs[0] = 32'h1FC00010; words[0] = 32'h24080001;
        addrs[1] = 32'hBFC00014; paddrs[1] = 32'h1FC00014; words[1] = 32'h25080002;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            pc_i = addrs[i]; ce_i = 1'b1;
            @(negedge clk);
            check_count++;
            if (pc_ready_o !== 1'b0) $display("[TB] FAIL seq%0d_c0_ready: got %0b expected 0", i, pc_ready_o);
            else pass_count++;
            next_cycle();
            bus_ack_i = 1'b1; bus_data_i = words[i];
            @(negedge clk);
            check_count++;
            if (bus_addr_o !== paddrs[i]) $display("[TB] FAIL seq%0d_addr: got %h expected %h", i, bus_addr_o, paddrs[i]);
            else pass_count++;
            check_count++;
            if (pc_ready_o !== 1'b0) $display("[TB] FAIL seq%0d_c1_ready: got %0b expected 0", i, pc_ready_o);
            else pass_count++;
            next_cycle();
            bus_ack_i = 1'b0; bus_data_i = 32'h0;
            @(negedge clk);
            check_count++;
            if (pc_ready_o !== 1'b1) $display("[TB] FAIL seq%0d_c2_ready: got %0b expected 1", i, pc_ready_o);
            else pass_count++;
            check_count++;
            if (pc_data_o !== words[i]) $display("[TB] FAIL seq%0d_data: got %h expected %h", i, pc_data_o, words[i]);
            else pass_count++;
            check_count++;
            if ({pc_tlbl_o, pc_mcheck_o} !== 2'b00) $display("[TB] FAIL seq%0d_flags: got %b expected 00", i, {pc_tlbl_o, pc_mcheck_o});
            else pass_count++;
        end
    endtask

    // Mapped-segment translation faults: refill/invalid, then multi-match.
    task automatic test_tlb_faults();
        logic [31:0] addrs [2];
        logic        hits [2];
        logic        multis [2];
        logic [1:0]  flags [2];
        addrs[0] = 32'h00400000; hits[0] = 1'b0; multis[0] = 1'b0; flags[0] = 2'b10;
        addrs[1] = 32'h00400004; hits[1] = 1'b1; multis[1] = 1'b1; flags[1] = 2'b01;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            pc_i = addrs[i]; ce_i = 1'b1;
            tlb_hit_i = hits[i]; tlb_valid_i = hits[i]; tlb_multi_i = multis[i];
            tlb_paddr_i = 32'h05550000;
            @(negedge clk);
            check_count++;
            if (tlb_vaddr_o !== addrs[i]) $display("[TB] FAIL tlbf%0d_vaddr: got %h expected %h", i, tlb_vaddr_o, addrs[i]);
            else pass_count++;
            check_count++;
            if (pc_ready_o !== 1'b0) $display("[TB] FAIL tlbf%0d_c0_ready: got %0b expected 0", i, pc_ready_o);
            else pass_count++;
            next_cycle();
            @(negedge clk);
            check_count++;
            if (bus_req_o !== 1'b0) $display("[TB] FAIL tlbf%0d_req: got %0b expected 0", i, bus_req_o);
            else pass_count++;
            check_count++;
            if (pc_ready_o !== 1'b1) $display("[TB] FAIL tlbf%0d_c1_ready: got %0b expected 1", i, pc_ready_o);
            else pass_count++;
            check_count++;
            if ({pc_tlbl_o, pc_mcheck_o} !== flags[i]) $display("[TB] FAIL tlbf%0d_flags: got %b expected %b", i, {pc_tlbl_o, pc_mcheck_o}, flags[i]);
            else pass_count++;
            check_count++;
            if (pc_data_o !== 32'h0) $display("[TB] FAIL tlbf%0d_data: got %h expected 00000000", i, pc_data_o);
            else pass_count++;
        end
    endtask

    // Mapped-segment fetch through a valid TLB entry.
    task automatic test_tlb_mapped();
        next_cycle();
        pc_i = 32'h00400000; ce_i = 1'b1;
        tlb_hit_i = 1'b1; tlb_valid_i = 1'b1; tlb_multi_i = 1'b0; tlb_paddr_i = 32'h01230000;
        next_cycle();
        bus_ack_i = 1'b1; bus_data_i = 32'h8FA40010;
        @(negedge clk);
        check_count++;
        if (bus_req_o !== 1'b1) $display("[TB] FAIL map_req: got %0b expected 1", bus_req_o);
        else pass_count++;
        check_count++;
        if (bus_addr_o !== 32'h01230000) $display("[TB] FAIL map_addr: got %h expected 01230000", bus_addr_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        tlb_hit_i = 1'b0; tlb_valid_i = 1'b0;
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b1) $display("[TB] FAIL map_ready: got %0b expected 1", pc_ready_o);
        else pass_count++;
        check_count++;
        if (pc_data_o !== 32'h8FA40010) $display("[TB] FAIL map_data: got %h expected 8fa40010", pc_data_o);
        else pass_count++;
        check_count++;
        if ({pc_tlbl_o, pc_mcheck_o} !== 2'b00) $display("[TB] FAIL map_flags: got %b expected 00", {pc_tlbl_o, pc_mcheck_o});
        else pass_count++;
    endtask

    task automatic test_misaligned();
        next_cycle();
        pc_i = 32'h80000002; ce_i = 1'b1;
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL mis_c0_ready: got %0b expected 0", pc_ready_o);
        else pass_count++;
        next_cycle();
        @(negedge clk);
        check_count++;
        if (bus_req_o !== 1'b0) $display("[TB] FAIL mis_req: got %0b expected 0", bus_req_o);
        else pass_count++;
        check_count++;
        if (pc_ready_o !== 1'b1) $display("[TB] FAIL mis_c1_ready: got %0b expected 1", pc_ready_o);
        else pass_count++;
        check_count++;
        if ({pc_data_o, pc_tlbl_o, pc_mcheck_o} !== 34'h0) $display("[TB] FAIL mis_result: got %h/%b%b expected 00000000/00", pc_data_o, pc_tlbl_o, pc_mcheck_o);
        else pass_count++;
    endtask

    // PC stage stalled: no fetch starts and a stray ack in IDLE is ignored.
    task automatic test_ce_low();
        next_cycle();
        pc_i = 32'h80001000; ce_i = 1'b0;
        bus_ack_i = 1'b1; bus_data_i = 32'hDEADBEEF;
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b1) $display("[TB] FAIL ce0_ready: got %0b expected 1", pc_ready_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        @(negedge clk);
        check_count++;
        if (bus_req_o !== 1'b0) $display("[TB] FAIL ce0_req: got %0b expected 0", bus_req_o);
        else pass_count++;
        ce_i = 1'b1;
        #1;
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL ce0_stray_ack: got ready %0b expected 0", pc_ready_o);
        else pass_count++;
        next_cycle();
        next_cycle();
        bus_ack_i = 1'b1; bus_data_i = 32'h11112222;
        next_cycle();
        bus_ack_i = 1'b0;
        @(negedge clk);
        check_count++;
        if (pc_data_o !== 32'h11112222) $display("[TB] FAIL ce0_resume_data: got %h expected 11112222", pc_data_o);
        else pass_count++;
    endtask

    // Redirect while the bus read is in flight.
    task automatic test_redirect();
        next_cycle();
        pc_i = 32'h80000100; ce_i = 1'b1;
        next_cycle();
        @(negedge clk);
        check_count++;
        if (bus_addr_o !== 32'h00000100) $display("[TB] FAIL redir_first_addr: got %h expected 00000100", bus_addr_o);
        else pass_count++;
        next_cycle();
        pc_i = 32'h80000200;
        @(negedge clk);
        check_count++;
        if (bus_addr_o !== 32'h00000100) $display("[TB] FAIL redir_addr_hold: got %h expected 00000100", bus_addr_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b1; bus_data_i = 32'hAAAA0100;
        next_cycle();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        @(negedge clk);
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL redir_stale_ready: got %0b expected 0", pc_ready_o);
        else pass_count++;
        check_count++;
        if (bus_req_o !== 1'b0) $display("[TB] FAIL redir_idle_req: got %0b expected 0", bus_req_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b1; bus_data_i = 32'hBBBB0200;
        @(negedge clk);
        check_count++;
        if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h00000200}) $display("[TB] FAIL redir_second_req: got %0b/%h expected 1/00000200", bus_req_o, bus_addr_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        @(negedge clk);
        check_count++;
        if ({pc_ready_o, pc_data_o} !== {1'b1, 32'hBBBB0200}) $display("[TB] FAIL redir_second_data: got %0b/%h expected 1/bbbb0200", pc_ready_o, pc_data_o);
        else pass_count++;
    endtask

    // Reset while a read is outstanding; a late ack must not become a result.
    task automatic test_reset_in_bus();
        next_cycle();
        pc_i = 32'h80000300; ce_i = 1'b1;
        next_cycle();
        @(negedge clk);
        check_count++;
        if (bus_req_o !== 1'b1) $display("[TB] FAIL rstbus_req_before: got %0b expected 1", bus_req_o);
        else pass_count++;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus_ack_i = 1'b1; bus_data_i = 32'hCCCCCCCC;
        @(negedge clk);
        check_count++;
        if (bus_req_o !== 1'b0) $display("[TB] FAIL rstbus_req_after: got %0b expected 0", bus_req_o);
        else pass_count++;
        check_count++;
        if (pc_ready_o !== 1'b0) $display("[TB] FAIL rstbus_ready: got %0b expected 0", pc_ready_o);
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        @(negedge clk);
        check_count++;
        if ({pc_ready_o, bus_req_o} !== 2'b01) $display("[TB] FAIL rstbus_late_ack: got ready/req %b expected 01", {pc_ready_o, bus_req_o});
        else pass_count++;
        next_cycle();
        bus_ack_i = 1'b1; bus_data_i = 32'h0C0C0300;
        next_cycle();
        bus_ack_i = 1'b0; bus_data_i = 32'h0;
        @(negedge clk);
        check_count++;
        if ({pc_ready_o, pc_data_o} !== {1'b1, 32'h0C0C0300}) $display("[TB] FAIL rstbus_refetch: got %0b/%h expected 1/0c0c0300", pc_ready_o, pc_data_o);
        else pass_count++;
    endtask

    initial begin
        test_reset();
        test_kseg0_fetch();
        test_back_to_back();
        test_tlb_faults();
        test_tlb_mapped();
        test_misaligned();
        test_ce_low();
        test_redirect();
        test_reset_in_bus();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish by %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/inst_fetch_port.md
Name: inst_fetch_port

Overview:
- Memory-side responder for the PC stage's instruction-fetch request (pc/ce in; data/ready/exception flags out).
- Translates the fetch virtual address: kseg0/kseg1 unmapped, all other segments via a combinational TLB lookup.
- Performs a single-word read on the memory bus and holds the result until the PC stage consumes it.
- ready low while a fetch is outstanding; the PC stage converts this into its stall request.

Parameters:
UNMAPPED_MASK, 32'h1FFFFFFF, physical = virtual & mask for kseg0 (0x80000000-0x9FFFFFFF) and kseg1 (0xA0000000-0xBFFFFFFF)
USE_TLB, 1, 0 = every segment uses UNMAPPED_MASK and TLB inputs are ignored

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
pc_i  in  32  fetch virtual address
ce_i  in  1  fetch enable; 0 = PC stage stalled
pc_data_o  out  32  instruction word for pc_i
pc_ready_o  out  1  pc_data_o and flags valid for current pc_i
pc_tlbl_o  out  1  TLB refill/invalid on fetch
pc_tlbs_o  out  1  store TLB fault; fetch never stores, constant 0
pc_mcheck_o  out  1  machine check (multiple TLB match)
tlb_vaddr_o  out  32  lookup address, equals pc_i
tlb_hit_i  in  1  matching entry found
tlb_valid_i  in  1  matching entry's V bit
tlb_multi_i  in  1  more than one entry matched
tlb_paddr_i  in  32  translated physical address
bus_req_o  out  1  bus read request
bus_addr_o  out  32  physical word address
bus_ack_i  in  1  read data valid this cycle
bus_data_i  in  32  read data

Behaviour:
- Result register: res_valid, res_addr[31:0], res_data[31:0], res_tlbl, res_mcheck.
- hit = res_valid & (res_addr == pc_i).
- pc_ready_o = ~ce_i | hit (combinational).
- pc_data_o = res_data, pc_tlbl_o = res_tlbl, pc_mcheck_o = res_mcheck. All are meaningful only when hit.
- Reset:
  - state = IDLE; res_valid = 0; res_addr, res_data and res flags = 0.
  - bus_req_o = 0; bus_addr_o = 0.
  - pc_ready_o is therefore 0 whenever ce_i = 1 after reset.
- Translation (combinational on pc_i):
  - Unmapped segment, or USE_TLB = 0: paddr = pc_i & UNMAPPED_MASK.
  - Otherwise: tlb_multi_i has priority and gives mcheck. Else ~tlb_hit_i or ~tlb_valid_i gives tlbl. Else paddr = tlb_paddr_i.
- FSM:
  - IDLE:
    - If ce_i & ~hit and pc_i[1:0] != 0 (misaligned): write result = {pc_i, data 0, no flags}, no bus access. The PC stage raises AdEL itself.
    - Else if ce_i & ~hit and translation faults: write result = {pc_i, data 0, tlbl/mcheck as computed}, no bus access.
    - Else if ce_i & ~hit: latch req_addr = pc_i, set bus_addr_o = paddr, set bus_req_o = 1, go to BUS.
    - Otherwise stay in IDLE.
  - BUS:
    - Hold bus_req_o = 1 and bus_addr_o stable until the bus_ack_i cycle.
    - On the ack edge: bus_req_o = 0, result = {req_addr, bus_data_i, no flags}, res_valid = 1, go to IDLE.
- Latency (counted from the first cycle a new pc_i is presented with ce_i = 1, cycle 0):
  - Exception or misaligned: ready in cycle 1.
  - Bus fetch: bus_req_o high from cycle 1. If ack arrives in cycle k (k >= 1), ready in cycle k+1.
  - Hit: ready in cycle 0.
- Sequential fetch pc -> pc+4 misses, so each new address costs at least 2 cycles.
- pc_i changes while in BUS (flush/branch):
  - The transaction is not aborted; the result is still written tagged with req_addr.
  - It is a non-hit for the new pc_i, so IDLE starts a new fetch on the next cycle.
- ce_i = 0: no new fetch starts; an in-flight BUS transaction completes; ready = 1.
- rst asserted during BUS: bus_req_o drops the next edge; any later ack is ignored (state IDLE, ack not used in IDLE).
- bus_ack_i in IDLE: ignored.

Test Plan:
- Reset, then pc_i=0x80000000, ce_i=1, ack 3 cycles after req -> bus_addr_o=0x00000000, ready=0 for cycles 0-3, ready=1 with data=bus word in cycle 4.
- pc_i=0xBFC00010 then pc_i=0xBFC00014 with 0-wait ack -> bus_addr_o 0x1FC00010 then 0x1FC00014; each address ready 2 cycles after presentation; tlbl/mcheck=0.
- pc_i=0x00400000, tlb_hit_i=0 -> no bus_req_o, ready in cycle 1, pc_tlbl_o=1, data=0. Repeat with tlb_hit=1, tlb_valid=1, tlb_multi_i=1 -> pc_mcheck_o=1, tlbl=0.
- pc_i=0x00400000, TLB hit/valid, tlb_paddr_i=0x01230000 -> bus_addr_o=0x01230000; data returned; flags 0.
- pc_i=0x80000002 -> no bus access, ready cycle 1, data 0, flags 0.
- Fetch 0x80000100 in BUS, change pc_i to 0x80000200 before ack -> first ack not reported as ready for 0x80000200; second req to 0x00000200 issued the cycle after the first ack edge. Separately, rst during BUS -> bus_req_o=0 next cycle, res_valid=0.
